// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered UART transmitter, LSB first, idle-high line.
// Define UART_TX_PARITY_EN to append an even parity bit after the data bits.
module uart_tx_buffered #(
  parameter int CLK_FREQ   = 25000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               s_valid,
  input  logic [DATA_BITS-1:0]               s_data,
  output logic                               s_ready,
  output logic                               tx,
  output logic                               tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int BW  = $clog2(STOP_BITS * CPB + 1);
  localparam int NW  = $clog2(DATA_BITS);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic par_q, par_d;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state_q, state_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [NW-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic tx_q, tx_d, busy_q, busy_d;
  logic push, pop, last;
  assign s_ready    = count_q != CW'(FIFO_DEPTH);
  assign push       = s_valid && s_ready;
  assign tx         = tx_q;
  assign tx_busy    = busy_q;
  assign fifo_count = count_q;
  assign last       = baud_q == BW'(CPB - 1);
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        baud_d = '0;
        pop    = count_q != '0;
      end
      START: if (last) begin
        state_d = DATA;
        baud_d  = '0;
        bit_d   = '0;
        tx_d    = shift_q[0];
      end
      DATA: if (last) begin
        baud_d = '0;
        if (bit_q == NW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
          tx_d    = par_q;
`else
          state_d = STOP;
          tx_d    = 1'b1;
`endif
        end else begin
          bit_d   = bit_q + 1'b1;
          shift_d = shift_q >> 1;
          tx_d    = shift_q[1];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (last) begin
        state_d = STOP;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
`endif
      STOP: if (baud_q == BW'(STOP_BITS * CPB - 1)) begin
        baud_d  = '0;
        pop     = count_q != '0;
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    // Popping always launches a start bit, from IDLE or straight out of the last stop cycle.
    if (pop) begin
      state_d = START;
      baud_d  = '0;
      shift_d = mem_q[rd_ptr_q];
      tx_d    = 1'b0;
      busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
      par_d   = ^mem_q[rd_ptr_q];
`endif
    end
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end
endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 25000000, meaning system clock in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, meaning line bit rate; CYCLES_PER_BIT = CLK_FREQ/BAUD_RATE (integer division, >= 2).
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame, legal 5..9.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame, legal 1 or 2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, meaning buffered words, power of two >= 2.
REQ-006 SHALL have port clk, input, 1, meaning the single clock (one clock; all logic on rising edge).
REQ-007 SHALL have port reset, input, 1, meaning reset, synchronous and active-high.
REQ-008 SHALL have port s_valid, input, 1, meaning producer presents a word.
REQ-009 SHALL have port s_data, input, DATA_BITS, meaning word to send, LSB first.
REQ-010 SHALL have port s_ready, output, 1, meaning FIFO accepts a word this cycle.
REQ-011 SHALL have port tx, output, 1, meaning serial line, idle high.
REQ-012 SHALL have port tx_busy, output, 1, meaning a frame is on the line.
REQ-013 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH+1), meaning words held in FIFO (excludes word in shifter).

Function
REQ-014 SHALL push s_data when s_valid && s_ready at a rising edge; s_ready = (fifo_count != FIFO_DEPTH), registered-state based, no combinational path from s_valid.
REQ-015 SHALL use FSM states IDLE, START, DATA, PARITY, STOP; every bit held exactly CYCLES_PER_BIT cycles via a baud counter reset to 0 on each state entry.
REQ-016 IDLE with fifo_count != 0: at the edge, pop head into shifter, tx <= 0, tx_busy <= 1, enter START; word pushed into empty FIFO is popped no earlier than the following edge (no bypass).
REQ-017 START -> DATA after CYCLES_PER_BIT; DATA shifts out DATA_BITS bits LSB first, then -> PARITY (macro defined) or STOP.
REQ-018 STOP drives tx = 1 for STOP_BITS*CYCLES_PER_BIT cycles.
REQ-019 At final STOP cycle: if FIFO non-empty, pop and enter START on the same edge (zero idle gap, back-to-back frames); else enter IDLE, tx_busy <= 0.
REQ-020 Frame length SHALL be (1+DATA_BITS+P+STOP_BITS)*CYCLES_PER_BIT cycles, P = 1 with parity, else 0.
REQ-021 Simultaneous push and pop SHALL leave fifo_count unchanged; push when full is ignored (s_ready low); FIFO pointers wrap modulo FIFO_DEPTH.
REQ-022 tx SHALL be a registered output, glitch-free, high in IDLE.
REQ-023 Changing s_data after acceptance SHALL NOT affect the queued word.

Reset
REQ-024 On reset high at a rising edge: tx = 1, tx_busy = 0, s_ready = 1, fifo_count = 0, FSM = IDLE, baud counter = 0, FIFO contents discarded.
REQ-025 Reset mid-frame SHALL abort the frame; tx returns high on the edge where reset is sampled, no partial resume after release.
REQ-026 First push accepted on the first edge with reset low.

Configuration
REQ-027 Macro UART_TX_PARITY_EN: when defined, PARITY state inserted after DATA, driving the even parity bit (XOR of all data bits) for CYCLES_PER_BIT cycles; when undefined, PARITY state and logic absent, DATA -> STOP directly.

Verification (CLK_FREQ=1000000, BAUD_RATE=100000 -> 10 cycles/bit, DATA_BITS=8, STOP_BITS=1, FIFO_DEPTH=4)
REQ-028 Push 0xA5 after reset -> tx low for 10 cycles, then 1,0,1,0,0,1,0,1 each 10 cycles, stop high 10 cycles; tx_busy high 100 cycles (110 with parity, parity bit 0).
REQ-029 Push 0x01, 0x80, 0xFF back-to-back -> three frames with no idle cycle between stop and next start; tx_busy continuous for 300 cycles (330 with parity; parity bits 1,1,0).
REQ-030 Hold s_valid high with 6 words while line busy -> fifo_count reaches 4, s_ready low, excess words stalled not lost; all 6 words emitted in order.
REQ-031 Assert reset at cycle 35 of a frame for 1 cycle -> tx = 1, tx_busy = 0, fifo_count = 0 next cycle; no further frame without new push.
REQ-032 DATA_BITS=5, STOP_BITS=2, push 0x15 -> 5 data bits 1,0,1,0,1 then stop high 20 cycles; frame 80 cycles (90 with parity, parity bit 1).
